input_debouncer: RTL and testbench

INPUT_DEBOUNCER -- requirements
Module: input_debouncer

---
 rtl/input_debouncer.sv | 127 ++++++++++++
 tb/tb_input_debouncer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/input_debouncer.sv
// rtl/input_debouncer.sv - two-flop synchronized switch debouncer with a qualify-then-accept FSM
// Optional macro DEBOUNCE_EDGE_PULSE_EN builds the registered rise/fall pulse outputs.
module input_debouncer #(
  parameter int DB_CYCLES = 1000,
  parameter int CNT_W     = 16
) (
  input  logic clk,
  input  logic res,
  input  logic din,
  output logic q,
  output logic rise,
  output logic fall,
  output logic busy
);

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    CHK_HI    = 2'd1,
    STABLE_HI = 2'd2,
    CHK_LO    = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;
  logic             s1;
  logic             s2;
  logic             q_nx;
  logic             acc_rise;
  logic             acc_fall;

  always_ff @(posedge clk) begin
    if (!res) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk) begin
    if (!res) begin
      state <= STABLE_LO;
      cnt   <= '0;
      q     <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      q     <= q_nx;
    end
  end

  // The counter is also cleared on abort/accept so it always idles at zero.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    acc_rise = 1'b0;
    acc_fall = 1'b0;
    unique case (state)
      STABLE_LO: begin
        if (s2) begin
          state_nx = CHK_HI;
          cnt_nx   = '0;
        end
      end
      CHK_HI: begin
        if (!s2) begin
          state_nx = STABLE_LO;
          cnt_nx   = '0;
        end else if (cnt == CNT_MAX) begin
          state_nx = STABLE_HI;
          cnt_nx   = '0;
          acc_rise = 1'b1;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      STABLE_HI: begin
        if (!s2) begin
          state_nx = CHK_LO;
          cnt_nx   = '0;
        end
      end
      CHK_LO: begin
        if (s2) begin
          state_nx = STABLE_HI;
          cnt_nx   = '0;
        end else if (cnt == CNT_MAX) begin
          state_nx = STABLE_LO;
          cnt_nx   = '0;
          acc_fall = 1'b1;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: begin
        state_nx = STABLE_LO;
        cnt_nx   = '0;
      end
    endcase
    q_nx = acc_rise ? 1'b1 : (acc_fall ? 1'b0 : q);
  end

  always_comb begin
    busy = (state == CHK_HI) || (state == CHK_LO);
  end

`ifdef DEBOUNCE_EDGE_PULSE_EN
  always_ff @(posedge clk) begin
    if (!res) begin
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= acc_rise;
      fall <= acc_fall;
    end
  end
`else
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// tb/tb_input_debouncer.sv - table-driven scoreboard bench for input_debouncer (DB_CYCLES 4 and 1)
module tb_input_debouncer;

`ifdef DEBOUNCE_EDGE_PULSE_EN
  localparam bit PULSE_EN = 1'b1;
`else
  localparam bit PULSE_EN = 1'b0;
`endif

  typedef struct {
    logic  res;
    logic  din;
    logic  q;
    logic  rise;
    logic  fall;
    logic  busy;
    string tag;
  } vec_t;

  logic clk = 1'b0;
  logic res4 = 1'b0, din4 = 1'b0;
  logic res1 = 1'b0, din1 = 1'b0;
  logic q4, rise4, fall4, busy4;
  logic q1, rise1, fall1, busy1;

  int checks = 0;
  int errors = 0;

  vec_t tbl[$];
  vec_t sb[$];

  always #5 clk = ~clk;

  input_debouncer #(.DB_CYCLES(4), .CNT_W(16)) u_dut (
    .clk(clk), .res(res4), .din(din4), .q(q4), .rise(rise4), .fall(fall4), .busy(busy4)
  );

  input_debouncer #(.DB_CYCLES(1), .CNT_W(4)) u_dut1 (
    .clk(clk), .res(res1), .din(din1), .q(q1), .rise(rise1), .fall(fall1), .busy(busy1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void add(input logic r, input logic d, input logic eq, input logic er,
                              input logic ef, input logic eb, input string tag);
    vec_t v;
    v.res  = r;
    v.din  = d;
    v.q    = eq;
    v.rise = er & PULSE_EN;
    v.fall = ef & PULSE_EN;
    v.busy = eb;
    v.tag  = tag;
    tbl.push_back(v);
  endfunction

  // sel 0 drives the DB_CYCLES=4 instance, sel 1 the DB_CYCLES=1 instance
  task automatic run_tbl(input int sel);
    vec_t v;
    vec_t e;
    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      @(negedge clk);
      if (sel == 0) begin
        res4 = v.res;
        din4 = v.din;
      end else begin
        res1 = v.res;
        din1 = v.din;
      end
      sb.push_back(v);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      if (sel == 0) begin
        chk({e.tag, "_q"},    q4,    e.q);
        chk({e.tag, "_rise"}, rise4, e.rise);
        chk({e.tag, "_fall"}, fall4, e.fall);
        chk({e.tag, "_busy"}, busy4, e.busy);
      end else begin
        chk({e.tag, "_q"},    q1,    e.q);
        chk({e.tag, "_rise"}, rise1, e.rise);
        chk({e.tag, "_fall"}, fall1, e.fall);
        chk({e.tag, "_busy"}, busy1, e.busy);
      end
    end
    tbl.delete();
  endtask

  initial begin
    // reset, then clean rise: busy after edges 3..6, q/rise after edge 7
    add(0, 0, 0, 0, 0, 0, "rst0");
    add(0, 0, 0, 0, 0, 0, "rst1");
    add(1, 1, 0, 0, 0, 0, "rise_e1");
    add(1, 1, 0, 0, 0, 0, "rise_e2");
    add(1, 1, 0, 0, 0, 1, "rise_e3");
    add(1, 1, 0, 0, 0, 1, "rise_e4");
    add(1, 1, 0, 0, 0, 1, "rise_e5");
    add(1, 1, 0, 0, 0, 1, "rise_e6");
    add(1, 1, 1, 1, 0, 0, "rise_e7");
    add(1, 1, 1, 0, 0, 0, "rise_e8");
    add(1, 1, 1, 0, 0, 0, "rise_e9");
    // clean fall
    add(1, 0, 1, 0, 0, 0, "fall_e1");
    add(1, 0, 1, 0, 0, 0, "fall_e2");
    add(1, 0, 1, 0, 0, 1, "fall_e3");
    add(1, 0, 1, 0, 0, 1, "fall_e4");
    add(1, 0, 1, 0, 0, 1, "fall_e5");
    add(1, 0, 1, 0, 0, 1, "fall_e6");
    add(1, 0, 0, 0, 1, 0, "fall_e7");
    add(1, 0, 0, 0, 0, 0, "fall_e8");
    // bounce: three high samples then low, rejected
    add(1, 1, 0, 0, 0, 0, "bnc_e1");
    add(1, 1, 0, 0, 0, 0, "bnc_e2");
    add(1, 1, 0, 0, 0, 1, "bnc_e3");
    add(1, 0, 0, 0, 0, 1, "bnc_e4");
    add(1, 0, 0, 0, 0, 1, "bnc_e5");
    add(1, 0, 0, 0, 0, 0, "bnc_e6");
    add(1, 0, 0, 0, 0, 0, "bnc_e7");
    add(1, 0, 0, 0, 0, 0, "bnc_e8");
    // start a qualification and stop at counter=2
    add(1, 1, 0, 0, 0, 0, "mid_e1");
    add(1, 1, 0, 0, 0, 0, "mid_e2");
    add(1, 1, 0, 0, 0, 1, "mid_e3");
    add(1, 1, 0, 0, 0, 1, "mid_e4");
    add(1, 1, 0, 0, 0, 1, "mid_e5");
    run_tbl(0);
    chk("mid_cnt2", 32'(u_dut.cnt), 32'd2);

    // reset mid-check, then re-qualify from the first non-reset edge
    add(0, 1, 0, 0, 0, 0, "mid_rst");
    run_tbl(0);
    chk("mid_rst_cnt", 32'(u_dut.cnt), 32'd0);
    add(1, 1, 0, 0, 0, 0, "post_e1");
    add(1, 1, 0, 0, 0, 0, "post_e2");
    add(1, 1, 0, 0, 0, 1, "post_e3");
    add(1, 1, 0, 0, 0, 1, "post_e4");
    add(1, 1, 0, 0, 0, 1, "post_e5");
    add(1, 1, 0, 0, 0, 1, "post_e6");
    add(1, 1, 1, 1, 0, 0, "post_e7");
    add(1, 1, 1, 0, 0, 0, "post_e8");
    run_tbl(0);

    // a reset glitch between edges must not disturb the state
    @(negedge clk);
    res4 = 1'b0;
    #2;
    res4 = 1'b1;
    @(posedge clk);
    #1;
    chk("glitch_q", q4, 1'b1);
    chk("glitch_busy", busy4, 1'b0);
    chk("glitch_rise", rise4, 1'b0);

    // DB_CYCLES=1 with a two-cycle pulse
    add(0, 0, 0, 0, 0, 0, "min_rst0");
    add(0, 0, 0, 0, 0, 0, "min_rst1");
    add(1, 1, 0, 0, 0, 0, "min_e1");
    add(1, 1, 0, 0, 0, 0, "min_e2");
    add(1, 0, 0, 0, 0, 1, "min_e3");
    add(1, 0, 1, 1, 0, 0, "min_e4");
    add(1, 0, 1, 0, 0, 1, "min_e5");
    add(1, 0, 0, 0, 1, 0, "min_e6");
    add(1, 0, 0, 0, 0, 0, "min_e7");
    run_tbl(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
